// File: rtl/miis_multi_rx_if.sv
// miis_multi_rx_if: I2S pins in, aligned sample bus and status out.
// master drives the mic pins, slave is the receiver.
interface miis_multi_rx_if #(
   parameter int N_LINES = 2,
   parameter int DATA_W  = 16
);
   logic                          mic_sck;
   logic                          mic_ws;
   logic [N_LINES-1:0]            mic_sd;
   logic [2*N_LINES*DATA_W-1:0]   mic_data;
   logic                          rx_done_pedge;
   logic                          frame_err;
   logic [15:0]                   frame_cnt;

   modport master (
      output mic_sck, mic_ws, mic_sd,
      input  mic_data, rx_done_pedge, frame_err, frame_cnt
   );
   modport slave (
      input  mic_sck, mic_ws, mic_sd,
      output mic_data, rx_done_pedge, frame_err, frame_cnt
   );
endinterface

// File: rtl/miis_multi_rx.sv
// miis_multi_rx: N-line I2S mic receiver publishing aligned L/R frames.
// Optional DC blocker on the published samples: `define MIIS_DCBLOCK_EN.
module miis_multi_rx #(
   parameter int N_LINES     = 2,
   parameter int SLOT_W      = 32,
   parameter int DATA_W      = 16,
   parameter int SYNC_STAGES = 2,
   parameter int DC_SHIFT    = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           enable,
   miis_multi_rx_if.slave bus
);
   localparam int CH = 2 * N_LINES;
   localparam logic [5:0] DW6 = 6'(DATA_W);
   localparam logic [6:0] SW7 = 7'(SLOT_W);

   typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_e;

   if (SLOT_W < 8 || SLOT_W > 63 || DATA_W > SLOT_W || DATA_W < 2 ||
       SYNC_STAGES < 2 || DC_SHIFT < 1) begin : g_bad_param
      $error("miis_multi_rx: illegal parameter set");
   end

   logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
   logic [SYNC_STAGES-1:0] ws_sync_q, ws_sync_d;
   logic [N_LINES-1:0]     sd_sync_q [SYNC_STAGES];
   logic [N_LINES-1:0]     sd_sync_d [SYNC_STAGES];
   logic                   sck_prev_q, ws_prev_q, ws_prev_d;
   state_e                 state_q, state_d;
   logic [5:0]             bit_cnt_q, bit_cnt_d;
   logic                   bad_q, bad_d;
   logic [DATA_W-1:0]      cap_q [N_LINES];
   logic [DATA_W-1:0]      cap_d [N_LINES];
   logic [DATA_W-1:0]      hold_q [CH];
   logic [DATA_W-1:0]      hold_d [CH];
   logic                   go_q, go_d, err_go_q, err_go_d;
   logic [CH*DATA_W-1:0]   mic_data_q, mic_data_d;
   logic                   rx_done_q, rx_done_d;
   logic                   frame_err_q, frame_err_d;
   logic [15:0]            frame_cnt_q, frame_cnt_d;
   logic                   pub_go;
   logic [DATA_W-1:0]      pub_src [CH];

   logic                   sck_s, ws_s, bit_ev, ws_chg, len_ok;
   logic [N_LINES-1:0]     sd_s;

   assign sck_s  = sck_sync_q[SYNC_STAGES-1];
   assign ws_s   = ws_sync_q[SYNC_STAGES-1];
   assign sd_s   = sd_sync_q[SYNC_STAGES-1];
   assign bit_ev = sck_s & ~sck_prev_q;
   assign ws_chg = bit_ev & (ws_s != ws_prev_q);
   assign len_ok = ({1'b0, bit_cnt_q} + 7'd1) == SW7;

   always_comb begin
      sck_sync_d   = {sck_sync_q[SYNC_STAGES-2:0], bus.mic_sck};
      ws_sync_d    = {ws_sync_q[SYNC_STAGES-2:0], bus.mic_ws};
      sd_sync_d[0] = bus.mic_sd;
      for (int i = 1; i < SYNC_STAGES; i++) sd_sync_d[i] = sd_sync_q[i-1];
   end

   // bit_cnt_q is the index of the bit arriving at this event
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      bad_d     = bad_q;
      cap_d     = cap_q;
      hold_d    = hold_q;
      ws_prev_d = ws_prev_q;
      go_d      = 1'b0;
      err_go_d  = 1'b0;
      if (bit_ev) begin
         ws_prev_d = ws_s;
         for (int k = 0; k < N_LINES; k++) begin
            if (bit_cnt_q < DW6)
               cap_d[k] = (cap_q[k] << 1) | DATA_W'(sd_s[k]);
         end
         if (bit_cnt_q != 6'd63) bit_cnt_d = bit_cnt_q + 6'd1;
      end
      if (ws_chg) begin
         bit_cnt_d = '0;
         if (len_ok) begin
            for (int k = 0; k < N_LINES; k++) begin
               if (ws_prev_q) hold_d[2*k+1] = cap_d[k];
               else           hold_d[2*k]   = cap_d[k];
            end
         end
         unique case (state_q)
            IDLE: begin
               if (!ws_s) begin
                  state_d = LEFT;
                  bad_d   = 1'b0;
               end
            end
            LEFT: begin
               state_d = RIGHT;
               if (!len_ok) begin
                  bad_d    = 1'b1;
                  err_go_d = 1'b1;
               end
            end
            RIGHT: begin
               state_d  = LEFT;
               bad_d    = 1'b0;
               go_d     = len_ok & ~bad_q;
               err_go_d = ~len_ok;
            end
            default: state_d = IDLE;
         endcase
      end
      if (!enable) begin
         state_d  = IDLE;
         go_d     = 1'b0;
         err_go_d = 1'b0;
      end
   end

`ifdef MIIS_DCBLOCK_EN
   localparam int AW = DATA_W + DC_SHIFT;

   logic signed [AW-1:0] acc_q [CH];
   logic signed [AW-1:0] acc_d [CH];
   logic [DATA_W-1:0]    y_q [CH];
   logic [DATA_W-1:0]    y_d [CH];
   logic [DATA_W-1:0]    mean [CH];
   logic signed [DATA_W:0] diff [CH];
   logic                 dc_go_q, dc_go_d;

   // diff is one bit wider than a sample so x - m never overflows
   always_comb begin
      acc_d   = acc_q;
      y_d     = y_q;
      dc_go_d = go_q & enable;
      for (int c = 0; c < CH; c++) begin
         mean[c] = DATA_W'(acc_q[c] >>> DC_SHIFT);
         diff[c] = {hold_q[c][DATA_W-1], hold_q[c]} -
                   {mean[c][DATA_W-1], mean[c]};
         if (dc_go_d) begin
            acc_d[c] = acc_q[c] + AW'(diff[c]);
            if (diff[c][DATA_W] != diff[c][DATA_W-1])
               y_d[c] = diff[c][DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                        : {1'b0, {(DATA_W-1){1'b1}}};
            else
               y_d[c] = diff[c][DATA_W-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q   <= '{default: '0};
         y_q     <= '{default: '0};
         dc_go_q <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         y_q     <= y_d;
         dc_go_q <= dc_go_d;
      end
   end

   always_comb begin
      pub_go  = dc_go_q & enable;
      pub_src = y_q;
   end
`else
   always_comb begin
      pub_go  = go_q & enable;
      pub_src = hold_q;
   end
`endif

   always_comb begin
      mic_data_d  = mic_data_q;
      rx_done_d   = 1'b0;
      frame_cnt_d = frame_cnt_q;
      frame_err_d = err_go_q & enable;
      if (pub_go) begin
         for (int c = 0; c < CH; c++) mic_data_d[c*DATA_W +: DATA_W] = pub_src[c];
         rx_done_d   = 1'b1;
         frame_cnt_d = frame_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sck_sync_q  <= '0;
         ws_sync_q   <= '0;
         sd_sync_q   <= '{default: '0};
         sck_prev_q  <= 1'b0;
         ws_prev_q   <= 1'b0;
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         bad_q       <= 1'b0;
         cap_q       <= '{default: '0};
         hold_q      <= '{default: '0};
         go_q        <= 1'b0;
         err_go_q    <= 1'b0;
         mic_data_q  <= '0;
         rx_done_q   <= 1'b0;
         frame_err_q <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         sck_sync_q  <= sck_sync_d;
         ws_sync_q   <= ws_sync_d;
         sd_sync_q   <= sd_sync_d;
         sck_prev_q  <= sck_s;
         ws_prev_q   <= ws_prev_d;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         bad_q       <= bad_d;
         cap_q       <= cap_d;
         hold_q      <= hold_d;
         go_q        <= go_d;
         err_go_q    <= err_go_d;
         mic_data_q  <= mic_data_d;
         rx_done_q   <= rx_done_d;
         frame_err_q <= frame_err_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign bus.mic_data      = mic_data_q;
   assign bus.rx_done_pedge = rx_done_q;
   assign bus.frame_err     = frame_err_q;
   assign bus.frame_cnt     = frame_cnt_q;
endmodule

// File: tb/tb_miis_multi_rx.sv
// tb_miis_multi_rx: random I2S frames vs slot-level reference model.
// Scoreboard queue filled at slot close, drained by an output monitor.
module tb_miis_multi_rx;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic enable = 1'b1;
   longint cyc = 0;

   miis_multi_rx_if #(.N_LINES(2), .DATA_W(16)) bus ();

   miis_multi_rx #(
      .N_LINES(2), .SLOT_W(32), .DATA_W(16), .SYNC_STAGES(2), .DC_SHIFT(8)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

`ifdef MIIS_DCBLOCK_EN
   localparam longint LAT = 5;
`else
   localparam longint LAT = 4;
`endif

   typedef struct {
      bit          is_err;
      logic [63:0] data;
      int          cnt;
      longint      cyc;
   } exp_t;

   exp_t exp_q[$];
   int n_chk = 0, n_err = 0;
   int exp_cnt = 0, exp_errs = 0, pub_seen = 0, err_seen = 0;
   logic [63:0] last_pub = '0;
   bit aligned = 0, left_ok = 0;
   logic [15:0] left_d [2];
   bit pend_side;
   int pend_len;
   logic [15:0] pend_d [2];
   longint acc_m [4] = '{0, 0, 0, 0};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   function automatic logic [15:0] dc_out(input int c, input logic [15:0] x);
`ifdef MIIS_DCBLOCK_EN
      longint m, d;
      m = acc_m[c] >>> 8;
      d = longint'($signed(x)) - m;
      acc_m[c] = acc_m[c] + d;
      if (d > 32767) d = 32767;
      if (d < -32768) d = -32768;
      return 16'(d);
`else
      return (c >= 0) ? x : x;
`endif
   endfunction

   // slot-level view: a right slot closing aligns, then L/R pairs form frames
   task automatic model_close();
      exp_t e;
      if (!aligned) begin
         if (pend_side) begin
            aligned = 1;
            left_ok = 0;
         end
         return;
      end
      e.data = last_pub;
      e.cnt = exp_cnt;
      e.cyc = cyc + LAT;
      if (!pend_side) begin
         left_ok = (pend_len == 32);
         left_d = pend_d;
         if (!left_ok) begin
            e.is_err = 1;
            exp_errs++;
            exp_q.push_back(e);
         end
      end else if (pend_len != 32) begin
         e.is_err = 1;
         exp_errs++;
         exp_q.push_back(e);
      end else if (left_ok) begin
         e.is_err = 0;
         e.data = {dc_out(3, pend_d[1]), dc_out(2, left_d[1]),
                   dc_out(1, pend_d[0]), dc_out(0, left_d[0])};
         exp_cnt++;
         e.cnt = exp_cnt;
         last_pub = e.data;
         exp_q.push_back(e);
      end
   endtask

   task automatic send_bit(input logic ws, input logic [1:0] sd, input bit close);
      @(negedge clk);
      bus.mic_sck = 1'b0;
      bus.mic_ws = ws;
      bus.mic_sd = sd;
      repeat (4) @(negedge clk);
      if (close) model_close();
      bus.mic_sck = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic send_slot(input bit side, input int len, input logic [15:0] d0,
                            input logic [15:0] d1, input int pause_at);
      logic [1:0] sd;
      pend_side = side;
      pend_len = len;
      pend_d[0] = d0;
      pend_d[1] = d1;
      for (int i = 0; i < len; i++) begin
         if (i == pause_at) begin
            @(negedge clk);
            enable = 1'b0;
            aligned = 0;
            repeat (100) @(negedge clk);
            enable = 1'b1;
         end
         sd = 2'($urandom);
         if (i < 16) begin
            sd[0] = d0[15-i];
            sd[1] = d1[15-i];
         end
         send_bit((i == len - 1) ? ~side : side, sd, i == len - 1);
      end
   endtask

   task automatic send_frame(input logic [15:0] l0, input logic [15:0] r0,
                             input logic [15:0] l1, input logic [15:0] r1,
                             input int llen, input int rlen);
      send_slot(1'b0, llen, l0, l1, -1);
      send_slot(1'b1, rlen, r0, r1, -1);
   endtask

   task automatic send_rand_frame();
      send_frame(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 32, 32);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && (bus.rx_done_pedge || bus.frame_err)) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_pulse", {62'd0, bus.rx_done_pedge, bus.frame_err}, 64'd0);
         end else begin
            e = exp_q.pop_front();
            if (bus.rx_done_pedge) begin
               pub_seen++;
               chk("pulse_kind_done", 64'(e.is_err), 64'd0);
               chk("mic_data", bus.mic_data, e.data);
               chk("frame_cnt", 64'(bus.frame_cnt), 64'(e.cnt));
               chk("publish_latency", 64'(cyc), 64'(e.cyc));
            end else begin
               err_seen++;
               chk("pulse_kind_err", 64'(e.is_err), 64'd1);
               chk("mic_data_held", bus.mic_data, e.data);
            end
         end
      end
   end

   initial begin
      bus.mic_sck = 1'b0;
      bus.mic_ws = 1'b0;
      bus.mic_sd = 2'b00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_mic_data", bus.mic_data, 64'd0);
      chk("reset_frame_cnt", 64'(bus.frame_cnt), 64'd0);
      chk("reset_rx_done", 64'(bus.rx_done_pedge), 64'd0);
      chk("reset_frame_err", 64'(bus.frame_err), 64'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // join mid-right-slot
      send_slot(1'b1, 11, 16'h5A5A, 16'hA5A5, -1);
      send_frame(16'h1234, 16'hABCD, 16'h8000, 16'h7FFF, 32, 32);
      repeat (6) send_rand_frame();

      send_frame(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 31, 32);
      send_rand_frame();
      send_frame(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 32, 33);
      send_rand_frame();

      send_slot(1'b0, 32, 16'($urandom), 16'($urandom), 12);
      send_slot(1'b1, 32, 16'($urandom), 16'($urandom), -1);
      repeat (3) send_rand_frame();

      repeat (4) send_frame(16'h1000, 16'h1000, 16'h1000, 16'h1000, 32, 32);
      repeat (4) send_rand_frame();

      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
      repeat (10) @(negedge clk);
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      chk("publish_count", 64'(pub_seen), 64'(exp_cnt));
      chk("error_count", 64'(err_seen), 64'(exp_errs));
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
